hazard_stall_controller: RTL and testbench
==========================================

# hazard_stall_controller

Central stall/flush sequencer for the 5-stage pipeline. Each cycle it decides which pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) hold, which take a bubble, and whether the PC advances. Inputs are load-use hazards, EX-stage control-flow redirects and instruction/data memory wait states. It also keeps a registered wait-state FSM, a data-memory timeout watchdog and saturating performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, default 255: number of consecutive dmem wait cycles after which `mem_timeout` is raised (range 1..65535).

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- id_rs1, id_rs2  in  5  source register indices of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  ID instruction actually reads rs1/rs2
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle
- imem_busy  in  1  fetch has not returned a valid instruction this cycle
- dmem_busy  in  1  MEM-stage data access is not complete this cycle
- pc_en  out  1  PC register loads its next value
- if_id_stall, if_id_flush  out  1  IF/ID hold and bubble controls
- id_ex_stall, id_ex_flush  out  1  ID/EX hold and bubble controls
- ex_mem_stall  out  1  EX/MEM hold
- mem_wb_flush  out  1  bubble into MEM/WB
- state  out  2  wait FSM state: 0 RUN, 1 MEM_WAIT, 2 FETCH_WAIT
- mem_timeout  out  1  sticky watchdog error
- stall_cycles  out  32  count of cycles with pc_en=0 while out of reset
- flush_events  out  32  count of redirect flushes

## Operation
- Control outputs are combinational from the current inputs and `rst`. Hazards resolve in the same cycle they appear.
- Load-use hazard: `ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd))`.
- Cases are evaluated in strict priority order, first match wins. Any output not listed for a case is 0.
  - D, `dmem_busy`: pc_en=0, if_id_stall=1, id_ex_stall=1, ex_mem_stall=1, mem_wb_flush=1.
  - R, `ex_redirect`: pc_en=1, if_id_flush=1, id_ex_flush=1.
  - L, load-use: pc_en=0, if_id_stall=1, id_ex_flush=1.
  - F, `imem_busy`: pc_en=0, if_id_flush=1.
  - N, none of the above: pc_en=1, all stall/flush outputs 0.
- Invariant: stall and flush are never both 1 for the same register.
- Next-state rules for the FSM:
  - case D → MEM_WAIT
  - case F → FETCH_WAIT
  - cases R, L, N → RUN
- Watchdog: `wait_cnt` (16 bits) counts consecutive case-D cycles and clears on any non-D cycle. When `wait_cnt` reaches MEM_TIMEOUT while still in D, `mem_timeout` sets. It stays set until reset.
- Counters:
  - `stall_cycles` increments in cases D, L and F.
  - `flush_events` increments in case R.
  - Both saturate at 32'hFFFF_FFFF and never wrap.

## Timing
- Reset: while rst=0 the outputs are forced to:
  - pc_en=0 and all *_stall=0
  - if_id_flush=1, id_ex_flush=1, mem_wb_flush=1
- On a clock edge with rst=0, the following clear: state=RUN, wait_cnt=0, mem_timeout=0, both counters=0.
- A reset asserted mid-stall takes effect at the next edge. Counters and the watchdog restart from 0.
- Latency: 0 cycles from input to control outputs. `state`, counters and `mem_timeout` update 1 cycle after the deciding cycle.
- Load-use produces exactly one bubble. On the next cycle the load has moved to MEM, so the hazard clears by itself.
- `ex_redirect` arriving with `dmem_busy`: D wins and the redirect is not counted. EX is frozen, so `ex_redirect` stays asserted and is taken on the first non-busy cycle.
- `ex_redirect` arriving with load-use or `imem_busy`: R wins. The PC loads the target and the stale fetch is discarded.
- With MEM_TIMEOUT=N and `dmem_busy` held continuously from cycle 0, `mem_timeout` reads 1 after the edge that ends cycle N.

## Test plan
- Reset: hold rst=0 for 3 cycles with random inputs → pc_en=0, all three flushes 1, state=0, counters 0. After release with idle inputs: pc_en=1 and all controls 0.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 → one cycle of pc_en=0, if_id_stall=1, id_ex_flush=1; stall_cycles=1. Repeat with ex_rd=0 → no stall.
- Redirect: ex_redirect=1 together with the load-use hazard and imem_busy=1 → pc_en=1, if_id_flush=1, id_ex_flush=1; flush_events=1, stall_cycles unchanged.
- Data wait: dmem_busy=1 for 4 cycles alongside ex_redirect=1 → four D cycles with state=1, then one R cycle; stall_cycles=4, flush_events=1.
- Watchdog: MEM_TIMEOUT=3, dmem_busy held for 5 cycles → mem_timeout=1 after the 4th edge and still 1 after dmem_busy drops. rst=0 clears it.
- Saturation: force stall_cycles to 32'hFFFF_FFFE, then apply 3 imem_busy cycles → count reads 32'hFFFF_FFFF and stays there; state=2 during the waits.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: per-cycle hold/bubble decisions,
// wait-state FSM, data-memory watchdog and saturating performance counters.
module hazard_stall_controller #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_uses_rs1_i,
    input  logic        id_uses_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_mem_read_i,
    input  logic        ex_redirect_i,
    input  logic        imem_busy_i,
    input  logic        dmem_busy_i,
    output logic        pc_en_o,
    output logic        if_id_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_stall_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_stall_o,
    output logic        mem_wb_flush_o,
    output logic [1:0]  state_o,
    output logic        mem_timeout_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_events_o
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_FETCH_WAIT = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEL_N = 3'd0,
        SEL_D = 3'd1,
        SEL_R = 3'd2,
        SEL_L = 3'd3,
        SEL_F = 3'd4
    } sel_e;

    localparam logic [15:0] TIMEOUT_LIM = 16'(MEM_TIMEOUT);

    logic        loadUse;
    sel_e        sel;
    logic        stallCase;

    state_e      state_q,      state_d;
    logic [15:0] waitCnt_q,    waitCnt_d;
    logic        timeout_q,    timeout_d;
    logic [31:0] stallCnt_q,   stallCnt_d;
    logic [31:0] flushCnt_q,   flushCnt_d;

    // Priority decode: a frozen MEM stage beats everything, then redirects, then load-use.
    always_comb begin
        loadUse = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                  ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                   (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));
        if (dmem_busy_i)        sel = SEL_D;
        else if (ex_redirect_i) sel = SEL_R;
        else if (loadUse)       sel = SEL_L;
        else if (imem_busy_i)   sel = SEL_F;
        else                    sel = SEL_N;
        stallCase = (sel == SEL_D) || (sel == SEL_L) || (sel == SEL_F);
    end

    always_comb begin
        pc_en_o        = 1'b0;
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        mem_wb_flush_o = 1'b0;
        if (!rst_i) begin
            if_id_flush_o  = 1'b1;
            id_ex_flush_o  = 1'b1;
            mem_wb_flush_o = 1'b1;
        end else begin
            case (sel)
                SEL_D: begin
                    if_id_stall_o  = 1'b1;
                    id_ex_stall_o  = 1'b1;
                    ex_mem_stall_o = 1'b1;
                    mem_wb_flush_o = 1'b1;
                end
                SEL_R: begin
                    pc_en_o       = 1'b1;
                    if_id_flush_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                end
                SEL_L: begin
                    if_id_stall_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                end
                SEL_F: begin
                    if_id_flush_o = 1'b1;
                end
                default: begin
                    pc_en_o = 1'b1;
                end
            endcase
        end
    end

    // Next-state: FSM tracks the wait cause, watchdog counts unbroken D runs, counters saturate.
    always_comb begin
        case (sel)
            SEL_D:   state_d = ST_MEM_WAIT;
            SEL_F:   state_d = ST_FETCH_WAIT;
            default: state_d = ST_RUN;
        endcase

        waitCnt_d = 16'd0;
        if (sel == SEL_D)
            waitCnt_d = (waitCnt_q == 16'hFFFF) ? waitCnt_q : waitCnt_q + 16'd1;

        timeout_d = timeout_q || ((sel == SEL_D) && (waitCnt_q >= TIMEOUT_LIM));

        stallCnt_d = stallCnt_q;
        if (stallCase && (stallCnt_q != 32'hFFFF_FFFF))
            stallCnt_d = stallCnt_q + 32'd1;

        flushCnt_d = flushCnt_q;
        if ((sel == SEL_R) && (flushCnt_q != 32'hFFFF_FFFF))
            flushCnt_d = flushCnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_RUN;
            waitCnt_q  <= 16'd0;
            timeout_q  <= 1'b0;
            stallCnt_q <= 32'd0;
            flushCnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            waitCnt_q  <= waitCnt_d;
            timeout_q  <= timeout_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign state_o        = state_q;
    assign mem_timeout_o  = timeout_q;
    assign stall_cycles_o = stallCnt_q;
    assign flush_events_o = flushCnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: priority cases, FSM, watchdog and counters.
module tb_hazard_stall_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  idRs1, idRs2, exRd;
    logic        usesRs1, usesRs2, exMemRead, exRedirect, imemBusy, dmemBusy;
    logic        pcEn, ifIdStall, ifIdFlush, idExStall, idExFlush, exMemStall, memWbFlush;
    logic [1:0]  state;
    logic        memTimeout;
    logic [31:0] stallCycles, flushEvents;
    logic [6:0]  ctl;

    int compared = 0;
    int mismatched = 0;

    // Control vector order: pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush
    localparam logic [6:0] CTL_RST = 7'b0010101;
    localparam logic [6:0] CTL_N   = 7'b1000000;
    localparam logic [6:0] CTL_D   = 7'b0101011;
    localparam logic [6:0] CTL_R   = 7'b1010100;
    localparam logic [6:0] CTL_L   = 7'b0100100;
    localparam logic [6:0] CTL_F   = 7'b0010000;

    hazard_stall_controller #(.MEM_TIMEOUT(3)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .id_rs1_i       (idRs1),
        .id_rs2_i       (idRs2),
        .id_uses_rs1_i  (usesRs1),
        .id_uses_rs2_i  (usesRs2),
        .ex_rd_i        (exRd),
        .ex_mem_read_i  (exMemRead),
        .ex_redirect_i  (exRedirect),
        .imem_busy_i    (imemBusy),
        .dmem_busy_i    (dmemBusy),
        .pc_en_o        (pcEn),
        .if_id_stall_o  (ifIdStall),
        .if_id_flush_o  (ifIdFlush),
        .id_ex_stall_o  (idExStall),
        .id_ex_flush_o  (idExFlush),
        .ex_mem_stall_o (exMemStall),
        .mem_wb_flush_o (memWbFlush),
        .state_o        (state),
        .mem_timeout_o  (memTimeout),
        .stall_cycles_o (stallCycles),
        .flush_events_o (flushEvents)
    );

    assign ctl = {pcEn, ifIdStall, ifIdFlush, idExStall, idExFlush, exMemStall, memWbFlush};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL time_limit: run did not finish, actual=timeout required=finish");
        $fatal(1, "[TB] time limit");
    end

    task automatic setIn(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic mr, input logic redir,
                         input logic ib, input logic db);
        idRs1 = rs1; usesRs1 = u1; idRs2 = rs2; usesRs2 = u2;
        exRd = rd; exMemRead = mr; exRedirect = redir; imemBusy = ib; dmemBusy = db;
    endtask

    task automatic idle();
        setIn(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b0;
        idle();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setIn(5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            #1;
            compared++;
            if (ctl !== CTL_RST) begin
                mismatched++;
                $display("[TB] FAIL reset_ctl[%0d]: actual=%b required=%b", i, ctl, CTL_RST);
            end
            tick();
        end
        compared++;
        if (state !== 2'd0 || stallCycles !== 32'd0 || flushEvents !== 32'd0 || memTimeout !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_regs: actual=state %0d stall %0d flush %0d to %b required=0/0/0/0",
                     state, stallCycles, flushEvents, memTimeout);
        end
        rst = 1'b1;
        idle();
        #1;
        compared++;
        if (ctl !== CTL_N) begin
            mismatched++;
            $display("[TB] FAIL reset_release_ctl: actual=%b required=%b", ctl, CTL_N);
        end
        tick();
    endtask

    task automatic test_load_use();
        doReset();
        setIn(5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        compared++;
        if (ctl !== CTL_L) begin
            mismatched++;
            $display("[TB] FAIL loaduse_rs2_ctl: actual=%b required=%b", ctl, CTL_L);
        end
        tick();
        compared++;
        if (stallCycles !== 32'd1 || state !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL loaduse_count: actual=stall %0d state %0d required=1/0", stallCycles, state);
        end
        idle();
        #1;
        compared++;
        if (ctl !== CTL_N) begin
            mismatched++;
            $display("[TB] FAIL loaduse_clears: actual=%b required=%b", ctl, CTL_N);
        end
        tick();
        setIn(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        compared++;
        if (ctl !== CTL_N) begin
            mismatched++;
            $display("[TB] FAIL loaduse_x0: actual=%b required=%b", ctl, CTL_N);
        end
        tick();
        setIn(5'd7, 1'b1, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        compared++;
        if (ctl !== CTL_L) begin
            mismatched++;
            $display("[TB] FAIL loaduse_rs1_ctl: actual=%b required=%b", ctl, CTL_L);
        end
        tick();
        setIn(5'd7, 1'b0, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        compared++;
        if (ctl !== CTL_N) begin
            mismatched++;
            $display("[TB] FAIL loaduse_unused_rs1: actual=%b required=%b", ctl, CTL_N);
        end
        tick();
        compared++;
        if (stallCycles !== 32'd2) begin
            mismatched++;
            $display("[TB] FAIL loaduse_total: actual=%0d required=2", stallCycles);
        end
    endtask

    task automatic test_redirect();
        doReset();
        setIn(5'd0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        compared++;
        if (ctl !== CTL_R) begin
            mismatched++;
            $display("[TB] FAIL redirect_ctl: actual=%b required=%b", ctl, CTL_R);
        end
        tick();
        compared++;
        if (flushEvents !== 32'd1 || stallCycles !== 32'd0 || state !== 2'd0) begin
            mismatched++;
            $display("[TB] FAIL redirect_count: actual=flush %0d stall %0d state %0d required=1/0/0",
                     flushEvents, stallCycles, state);
        end
    endtask

    task automatic test_data_wait();
        doReset();
        for (int i = 0; i < 4; i++) begin
            setIn(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
            #1;
            compared++;
            if (ctl !== CTL_D) begin
                mismatched++;
                $display("[TB] FAIL dwait_ctl[%0d]: actual=%b required=%b", i, ctl, CTL_D);
            end
            tick();
            compared++;
            if (state !== 2'd1) begin
                mismatched++;
                $display("[TB] FAIL dwait_state[%0d]: actual=%0d required=1", i, state);
            end
        end
        dmemBusy = 1'b0;
        #1;
        compared++;
        if (ctl !== CTL_R) begin
            mismatched++;
            $display("[TB] FAIL dwait_redirect_ctl: actual=%b required=%b", ctl, CTL_R);
        end
        tick();
        compared++;
        if (state !== 2'd0 || stallCycles !== 32'd4 || flushEvents !== 32'd1) begin
            mismatched++;
            $display("[TB] FAIL dwait_counts: actual=state %0d stall %0d flush %0d required=0/4/1",
                     state, stallCycles, flushEvents);
        end
    endtask

    task automatic test_watchdog();
        doReset();
        setIn(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int e = 1; e <= 5; e++) begin
            tick();
            compared++;
            if (memTimeout !== ((e >= 4) ? 1'b1 : 1'b0)) begin
                mismatched++;
                $display("[TB] FAIL watchdog_edge%0d: actual=%b required=%b", e, memTimeout, (e >= 4));
            end
        end
        idle();
        tick();
        compared++;
        if (memTimeout !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL watchdog_sticky: actual=%b required=1", memTimeout);
        end
        doReset();
        compared++;
        if (memTimeout !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL watchdog_reset: actual=%b required=0", memTimeout);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] expCtl [5];
        logic [1:0] expState [5];
        logic [31:0] expStall [5];
        logic [31:0] expFlush [5];
        doReset();
        expCtl   = '{CTL_F, CTL_L, CTL_R, CTL_D, CTL_N};
        expState = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd0};
        expStall = '{32'd1, 32'd2, 32'd2, 32'd3, 32'd3};
        expFlush = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1};
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: setIn(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
                1: setIn(5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0);
                2: setIn(5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0);
                3: setIn(5'd9, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1);
                default: idle();
            endcase
            #1;
            compared++;
            if (ctl !== expCtl[i]) begin
                mismatched++;
                $display("[TB] FAIL b2b_ctl[%0d]: actual=%b required=%b", i, ctl, expCtl[i]);
            end
            tick();
            compared++;
            if (state !== expState[i] || stallCycles !== expStall[i] || flushEvents !== expFlush[i]) begin
                mismatched++;
                $display("[TB] FAIL b2b_regs[%0d]: actual=%0d/%0d/%0d required=%0d/%0d/%0d", i,
                         state, stallCycles, flushEvents, expState[i], expStall[i], expFlush[i]);
            end
        end
    endtask

    task automatic test_saturation();
        doReset();
        force dut.stallCnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stallCnt_q;
        setIn(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            compared++;
            if (stallCycles !== 32'hFFFF_FFFF || state !== 2'd2) begin
                mismatched++;
                $display("[TB] FAIL saturate[%0d]: actual=%h state %0d required=ffffffff state 2",
                         i, stallCycles, state);
            end
        end
        idle();
        tick();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        #2;
        test_reset();
        test_load_use();
        test_redirect();
        test_data_wait();
        test_watchdog();
        test_back_to_back();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
